// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the icache, absorbs misses, applies redirects and halts on HLT.
// Zero-cycle hit path; redirects taken during a miss are parked and applied once the miss completes.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] icache_addr,
  output logic        icache_req,
  input  logic [15:0] icache_data,
  input  logic        icache_valid,
  output logic [15:0] PC_out_to_IFID,
  output logic [15:0] imem_data_out_to_IFID,
  output logic        stall_IFID,
  output logic        flush_IFID,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, MISS_WAIT, HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] pending_target, pending_target_nxt;
  logic        pending_valid, pending_valid_nxt;
  logic        fetch_done;
  logic        is_hlt;

  assign fetch_done = icache_valid && (state != HALT);
  assign is_hlt     = (icache_data[15:12] == HLT_OPCODE);

  assign icache_addr           = pc;
  assign icache_req            = !rst && (state != HALT);
  assign PC_out_to_IFID        = pc + 16'd2;
  assign imem_data_out_to_IFID = (!rst && fetch_done) ? icache_data : 16'h0000;
  assign halted                = !rst && (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      pending_target <= 16'h0000;
      pending_valid  <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      pending_target <= pending_target_nxt;
      pending_valid  <= pending_valid_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    pc_nxt             = pc;
    pending_target_nxt = pending_target;
    pending_valid_nxt  = pending_valid;
    stall_IFID         = 1'b0;
    flush_IFID         = 1'b0;

    if (rst) begin
      flush_IFID = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            pc_nxt     = branch_target;
            flush_IFID = 1'b1;
          end else if (stall) begin
            stall_IFID = 1'b1;
          end else if (!icache_valid) begin
            flush_IFID = 1'b1;
            state_nxt  = MISS_WAIT;
          end else if (is_hlt) begin
            state_nxt = HALT;
          end else begin
            pc_nxt = pc + 16'd2;
          end
        end

        MISS_WAIT: begin
          // The address stays on the bus until the cache answers; redirects are deferred.
          if (branch_taken) begin
            flush_IFID = 1'b1;
            if (icache_valid) begin
              pc_nxt            = branch_target;
              pending_valid_nxt = 1'b0;
              state_nxt         = RUN;
            end else begin
              pending_target_nxt = branch_target;
              pending_valid_nxt  = 1'b1;
            end
          end else if (!icache_valid) begin
            flush_IFID = 1'b1;
          end else if (pending_valid) begin
            flush_IFID        = 1'b1;
            pc_nxt            = pending_target;
            pending_valid_nxt = 1'b0;
            state_nxt         = RUN;
          end else if (stall) begin
            // Word not captured; RUN reissues the same address.
            stall_IFID = 1'b1;
            state_nxt  = RUN;
          end else if (is_hlt) begin
            state_nxt = HALT;
          end else begin
            pc_nxt    = pc + 16'd2;
            state_nxt = RUN;
          end
        end

        HALT: begin
          flush_IFID = 1'b1;
          if (branch_taken) begin
            pc_nxt    = branch_target;
            state_nxt = RUN;
          end
        end

        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hits, misses, redirects, stalls, HLT, PC wrap and reset mid-miss.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] icache_addr;
  logic        icache_req;
  logic [15:0] icache_data;
  logic        icache_valid;
  logic [15:0] PC_out_to_IFID;
  logic [15:0] imem_data_out_to_IFID;
  logic        stall_IFID;
  logic        flush_IFID;
  logic        halted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .stall                 (stall),
    .branch_taken          (branch_taken),
    .branch_target         (branch_target),
    .icache_addr           (icache_addr),
    .icache_req            (icache_req),
    .icache_data           (icache_data),
    .icache_valid          (icache_valid),
    .PC_out_to_IFID        (PC_out_to_IFID),
    .imem_data_out_to_IFID (imem_data_out_to_IFID),
    .stall_IFID            (stall_IFID),
    .flush_IFID            (flush_IFID),
    .halted                (halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so combinational outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic br,
                       input logic [15:0] tgt, input logic st);
    icache_valid  = v;
    icache_data   = d;
    branch_taken  = br;
    branch_target = tgt;
    stall         = st;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 16'hABCD, 1'b0, 16'h0000, 1'b0);
    cyc();
    chk("rst_req",   {15'b0, icache_req}, 16'h0000);
    chk("rst_flush", {15'b0, flush_IFID}, 16'h0001);
    chk("rst_stall", {15'b0, stall_IFID}, 16'h0000);
    chk("rst_halt",  {15'b0, halted},     16'h0000);
    chk("rst_pcout", PC_out_to_IFID,      16'h0002);
    chk("rst_data",  imem_data_out_to_IFID, 16'h0000);
    chk("rst_addr",  icache_addr,         16'h0000);

    // Back-to-back hits
    rst = 1'b0;
    drive(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
    chk("hit0_addr",  icache_addr,    16'h0000);
    chk("hit0_pcout", PC_out_to_IFID, 16'h0002);
    chk("hit0_data",  imem_data_out_to_IFID, 16'h1000);
    chk("hit0_flush", {15'b0, flush_IFID}, 16'h0000);
    chk("hit0_req",   {15'b0, icache_req}, 16'h0001);
    cyc();
    chk("hit1_pcout", PC_out_to_IFID, 16'h0004);
    chk("hit1_flush", {15'b0, flush_IFID}, 16'h0000);
    cyc();
    chk("hit2_pcout", PC_out_to_IFID, 16'h0006);
    chk("hit2_flush", {15'b0, flush_IFID}, 16'h0000);
    cyc();
    cyc();
    chk("pc8_addr", icache_addr, 16'h0008);

    // Stall two cycles, then stall coinciding with a branch
    drive(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1);
    chk("stall0_st", {15'b0, stall_IFID}, 16'h0001);
    chk("stall0_fl", {15'b0, flush_IFID}, 16'h0000);
    cyc();
    chk("stall1_addr", icache_addr, 16'h0008);
    chk("stall1_st", {15'b0, stall_IFID}, 16'h0001);
    cyc();
    chk("stall2_addr", icache_addr, 16'h0008);
    drive(1'b1, 16'h1000, 1'b1, 16'h0040, 1'b1);
    chk("stbr_fl", {15'b0, flush_IFID}, 16'h0001);
    chk("stbr_st", {15'b0, stall_IFID}, 16'h0000);
    cyc();
    chk("stbr_addr", icache_addr, 16'h0040);

    // Three-cycle miss at 0x0010
    drive(1'b1, 16'h1000, 1'b1, 16'h0010, 1'b0);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("miss_addr",  icache_addr, 16'h0010);
      chk("miss_flush", {15'b0, flush_IFID}, 16'h0001);
      chk("miss_req",   {15'b0, icache_req}, 16'h0001);
      cyc();
    end
    drive(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0);
    chk("missdone_data",  imem_data_out_to_IFID, 16'h1234);
    chk("missdone_flush", {15'b0, flush_IFID}, 16'h0000);
    chk("missdone_pcout", PC_out_to_IFID, 16'h0012);
    cyc();
    chk("missdone_addr", icache_addr, 16'h0012);

    // Branch during a two-cycle miss at 0x0020
    drive(1'b1, 16'h1000, 1'b1, 16'h0020, 1'b0);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    cyc();
    drive(1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0);
    chk("mbr_addr", icache_addr, 16'h0020);
    cyc();
    drive(1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0);
    chk("mbr_hold", icache_addr, 16'h0020);
    chk("mbr_discard", {15'b0, flush_IFID}, 16'h0001);
    cyc();
    drive(1'b1, 16'h2000, 1'b0, 16'h0000, 1'b0);
    chk("mbr_redir", icache_addr, 16'h0100);
    chk("mbr_pvclr", {15'b0, flush_IFID}, 16'h0000);
    chk("mbr_data",  imem_data_out_to_IFID, 16'h2000);
    cyc();
    chk("mbr_next", icache_addr, 16'h0102);

    // HLT at 0x0030, then resume via branch to 0x0050
    drive(1'b1, 16'h1000, 1'b1, 16'h0030, 1'b0);
    cyc();
    drive(1'b1, 16'hF000, 1'b0, 16'h0000, 1'b0);
    chk("hlt_data",  imem_data_out_to_IFID, 16'hF000);
    chk("hlt_flush", {15'b0, flush_IFID}, 16'h0000);
    cyc();
    chk("hlt_halted", {15'b0, halted}, 16'h0001);
    chk("hlt_req",    {15'b0, icache_req}, 16'h0000);
    chk("hlt_flush2", {15'b0, flush_IFID}, 16'h0001);
    cyc();
    chk("hlt_frozen", icache_addr, 16'h0030);
    chk("hlt_stay",   {15'b0, halted}, 16'h0001);
    drive(1'b1, 16'hF000, 1'b1, 16'h0050, 1'b0);
    cyc();
    chk("resume_halt", {15'b0, halted}, 16'h0000);
    chk("resume_addr", icache_addr, 16'h0050);
    chk("resume_req",  {15'b0, icache_req}, 16'h0001);

    // HLT word with a simultaneous branch: the branch wins
    cyc();
    chk("hltbr_halt", {15'b0, halted}, 16'h0000);
    chk("hltbr_addr", icache_addr, 16'h0050);

    // PC wrap
    drive(1'b1, 16'h1000, 1'b1, 16'hFFFE, 1'b0);
    cyc();
    drive(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
    chk("wrap_pcout", PC_out_to_IFID, 16'h0000);
    cyc();
    chk("wrap_addr", icache_addr, 16'h0000);

    // Reset while a miss with a pending redirect is outstanding
    drive(1'b1, 16'h1000, 1'b1, 16'h0080, 1'b0);
    cyc();
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    cyc();
    drive(1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0);
    cyc();
    chk("prerst_addr", icache_addr, 16'h0080);
    rst = 1'b1;
    drive(1'b1, 16'h3000, 1'b0, 16'h0000, 1'b0);
    chk("rstmid_req", {15'b0, icache_req}, 16'h0000);
    cyc();
    rst = 1'b0;
    drive(1'b1, 16'h3000, 1'b0, 16'h0000, 1'b0);
    chk("rstmid_addr",  icache_addr, 16'h0000);
    chk("rstmid_run",   {15'b0, flush_IFID}, 16'h0000);
    chk("rstmid_pcout", PC_out_to_IFID, 16'h0002);
    cyc();
    chk("rstmid_next", icache_addr, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
